img_wr_ctrl: RTL and testbench
==============================

IMG_WR_CTRL -- requirements
Module: img_wr_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-high reset: clk is the clock, rst is the reset.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- start  in  1  one-cycle pulse; begin frame readout
- abort  in  1  one-cycle pulse; cancel frame
- img_width  in  13  columns per row; sampled on accepted start
- img_height  in  13  rows per frame; sampled on accepted start
- base_addr  in  18  SRAM word address of pixel (0,0); sampled on accepted start
- sram_req  out  1  read request; held until ack
- sram_addr  out  18  read address; stable while sram_req=1
- sram_ack  in  1  one-cycle read completion; sram_rdata valid this cycle
- sram_rdata  in  32  read data
- pix_valid  out  1  output pixel word valid
- pix_ready  in  1  downstream accepts when pix_valid & pix_ready
- pix_data  out  32  pixel word
- pix_eol  out  1  qualifies last column of a row
- pix_eof  out  1  qualifies last pixel of frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last pixel accepted
- err  out  1  one-cycle pulse on SRAM timeout (REQ-020 only)

Function
REQ-003 States SHALL be IDLE, REQ, OUT, DONE; encoding free.
REQ-004 IDLE: start with img_width!=0 and img_height!=0 SHALL latch width, height, base_addr, clear col/row counters, set addr register to base_addr, go REQ.
REQ-005 IDLE: start with img_width=0 or img_height=0 SHALL go DONE with no SRAM request.
REQ-006 start while busy=1 SHALL be ignored.
REQ-007 REQ: sram_req=1, sram_addr=addr register; on sram_ack SHALL capture sram_rdata into pix_data, set eol/eof flags, go OUT.
REQ-008 OUT: pix_valid=1; pix_data, pix_eol, pix_eof SHALL be held stable until pix_ready=1.
REQ-009 On handshake in OUT: if not last pixel, SHALL increment addr by 1 (18-bit, wraps modulo 2^18), advance counters, go REQ; if last pixel, go DONE.
REQ-010 Column counter 13-bit, counts 0..width-1; at width-1 SHALL roll to 0 and increment row counter (0..height-1).
REQ-011 pix_eol=1 iff col=width-1; pix_eof=1 iff col=width-1 and row=height-1.
REQ-012 Minimum pixel period SHALL be 2 cycles (REQ->OUT->REQ); sram_req SHALL deassert the cycle after ack.
REQ-013 DONE: done=1 for exactly one cycle, then IDLE.
REQ-014 busy SHALL be 1 in REQ and OUT, 0 in IDLE and DONE.
REQ-015 abort in any non-IDLE state SHALL go IDLE next cycle, drop sram_req/pix_valid, no done pulse; abort in IDLE SHALL have no effect; abort SHALL take priority over same-cycle ack or handshake.
REQ-016 sram_ack outside REQ SHALL be ignored.
REQ-017 Total pixels emitted per frame SHALL equal width*height, addresses base_addr..base_addr+width*height-1 in raster order.

Reset
REQ-018 rst SHALL asynchronously force IDLE; sram_req, pix_valid, pix_eol, pix_eof, busy, done, err = 0; pix_data, sram_addr, counters = 0.
REQ-019 rst asserted mid-frame SHALL discard the frame; after release the block SHALL await a new start.

Configuration
REQ-020 Macro IMG_WR_TIMEOUT_EN defined: 8-bit wait counter cleared on entering REQ, increments each REQ cycle without ack; at count 255 without ack SHALL pulse err one cycle and go IDLE (no done).
REQ-021 IMG_WR_TIMEOUT_EN undefined: no wait counter; REQ waits indefinitely; err tied 0.

Verification
REQ-022 width=3,height=2,base=0x100, ack 1 cycle after req, ready=1 -> addrs 0x100..0x105, eol on pixels 3 and 6, eof on pixel 6, done one cycle after.
REQ-023 width=4,height=1, pix_ready low 5 cycles on pixel 2 -> pix_data/eol/eof stable, no new sram_req until handshake.
REQ-024 width=0,height=5 start -> done 1 cycle later, sram_req never asserted, busy stays 0.
REQ-025 abort same cycle as sram_ack on pixel 2 of 3x3 -> IDLE next cycle, no done, restart with base=0x3FFFE wraps to 0x00000 at pixel 3.
REQ-026 rst mid-frame then start while busy check; with IMG_WR_TIMEOUT_EN, withhold ack -> err at 255th wait cycle, IDLE; without macro, no err.

Source files
------------

// File: rtl/img_wr_ctrl.sv
// Reads a width x height frame from SRAM one word at a time and streams it out on a valid/ready pixel port.
// Define IMG_WR_TIMEOUT_EN to enable the SRAM acknowledge watchdog (err pulse after 255 unanswered wait cycles).
module img_wr_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [12:0] img_width,
    input  logic [12:0] img_height,
    input  logic [17:0] base_addr,
    output logic        sram_req,
    output logic [17:0] sram_addr,
    input  logic        sram_ack,
    input  logic [31:0] sram_rdata,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [31:0] pix_data,
    output logic        pix_eol,
    output logic        pix_eof,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_OUT,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [12:0] r_width;
    logic [12:0] r_height;
    logic [12:0] r_col;
    logic [12:0] r_row;
    logic [17:0] r_addr;
    logic [31:0] r_data;
    logic        r_eol;
    logic        r_eof;
    logic        w_zero_dim;
    logic        w_last_col;
    logic        w_last_row;
    logic        w_timeout;

    assign w_zero_dim = (img_width == 13'd0) || (img_height == 13'd0);
    assign w_last_col = (r_col == (r_width - 13'd1));
    assign w_last_row = (r_row == (r_height - 13'd1));

`ifdef IMG_WR_TIMEOUT_EN
    logic [7:0] r_wait;

    // Counts REQ cycles without an acknowledge; zero whenever a fresh request begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= 8'd0;
        end else if ((r_state != S_REQ) || sram_ack) begin
            r_wait <= 8'd0;
        end else begin
            r_wait <= r_wait + 8'd1;
        end
    end

    assign w_timeout = (r_state == S_REQ) && !sram_ack && (r_wait == 8'hFF);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort and timeout outrank a same-cycle acknowledge or handshake.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_zero_dim ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (abort || w_timeout) begin
                    w_next = S_IDLE;
                end else if (sram_ack) begin
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (pix_ready) begin
                    w_next = r_eof ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_width  <= 13'd0;
            r_height <= 13'd0;
            r_col    <= 13'd0;
            r_row    <= 13'd0;
            r_addr   <= 18'd0;
            r_data   <= 32'd0;
            r_eol    <= 1'b0;
            r_eof    <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                if (start && !w_zero_dim) begin
                    r_width  <= img_width;
                    r_height <= img_height;
                    r_col    <= 13'd0;
                    r_row    <= 13'd0;
                    r_addr   <= base_addr;
                end
            end else if (r_state == S_REQ) begin
                if (!abort && sram_ack) begin
                    r_data <= sram_rdata;
                    r_eol  <= w_last_col;
                    r_eof  <= w_last_col && w_last_row;
                end
            end else if (r_state == S_OUT) begin
                if (!abort && pix_ready && !r_eof) begin
                    r_addr <= r_addr + 18'd1;
                    if (w_last_col) begin
                        r_col <= 13'd0;
                        r_row <= r_row + 13'd1;
                    end else begin
                        r_col <= r_col + 13'd1;
                    end
                end
            end
        end
    end

    assign sram_req  = (r_state == S_REQ);
    assign sram_addr = r_addr;
    assign pix_valid = (r_state == S_OUT);
    assign pix_data  = r_data;
    assign pix_eol   = r_eol && (r_state == S_OUT);
    assign pix_eof   = r_eof && (r_state == S_OUT);
    assign busy      = (r_state == S_REQ) || (r_state == S_OUT);
    assign done      = (r_state == S_DONE);
    assign err       = w_timeout;

endmodule

// File: tb/tb_img_wr_ctrl.sv
// Scoreboard bench for img_wr_ctrl: expected reads and pixels are queued when a frame is started,
// and a negedge monitor pops and compares them as the DUT presents reads and pixels.
module tb_img_wr_ctrl;

    typedef struct packed {
        logic [31:0] data;
        logic        eol;
        logic        eof;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [12:0] img_width = 13'd0;
    logic [12:0] img_height = 13'd0;
    logic [17:0] base_addr = 18'd0;
    logic        sram_req;
    logic [17:0] sram_addr;
    logic        sram_ack = 1'b0;
    logic [31:0] sram_rdata = 32'd0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [31:0] pix_data;
    logic        pix_eol;
    logic        pix_eof;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;

    logic [17:0] expAddrQ[$];
    pix_t        expPixQ[$];

    // Stimulus control shared between main sequence and the responder processes
    int ackMode = 1;
    int ackLat = 1;
    int waitCnt = 0;
    bit spuriousEn = 1'b0;
    int readyMode = 1;
    int stallIdx = 0;
    int stallLeft = 0;
    int hsCount = 0;
    bit zeroStart = 1'b0;

    // Monitor state
    logic        doneArm = 1'b0;
    logic        expDone;
    logic        expErr;
    logic        idlePrev = 1'b0;
    logic        stallPrev = 1'b0;
    logic        reqHoldPrev = 1'b0;
    logic [31:0] prevData = 32'd0;
    logic        prevEol = 1'b0;
    logic        prevEof = 1'b0;
    logic [17:0] prevAddr = 18'd0;
    int          reqRun = 0;
    logic [17:0] popAddr;
    pix_t        popPix;

    img_wr_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .img_width  (img_width),
        .img_height (img_height),
        .base_addr  (base_addr),
        .sram_req   (sram_req),
        .sram_addr  (sram_addr),
        .sram_ack   (sram_ack),
        .sram_rdata (sram_rdata),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_eol    (pix_eol),
        .pix_eof    (pix_eof),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Contents of the modelled SRAM: every word is a fixed scramble of its address.
    function automatic logic [31:0] sramWord(input logic [17:0] a);
        return ({14'd0, a} * 32'd40503) ^ 32'h5A5A_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Drives a start pulse and queues the raster-order reads and pixels the frame should produce.
    task automatic applyStimulus(input int w, input int h, input logic [17:0] b);
        logic [17:0] a;
        pix_t e;
        hsCount = 0;
        for (int i = 0; i < w * h; i++) begin
            a = b + 18'(i);
            e.data = sramWord(a);
            e.eol = ((i % w) == (w - 1));
            e.eof = (i == (w * h - 1));
            expAddrQ.push_back(a);
            expPixQ.push_back(e);
        end
        @(posedge clk);
        #1;
        img_width = 13'(w);
        img_height = 13'(h);
        base_addr = b;
        start = 1'b1;
        if (w == 0 || h == 0) zeroStart = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitFrameEnd(input int maxCycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || done) && n < maxCycles);
        checkOutput("frame_end_in_time", 32'(n < maxCycles), 32'd1);
    endtask

    // SRAM responder: acknowledges after a chosen latency, sometimes pulses ack with no request.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            sram_ack = 1'b0;
            waitCnt = 0;
        end else if (sram_req && ackMode != 2 && waitCnt >= ackLat) begin
            sram_ack = 1'b1;
            sram_rdata = sramWord(sram_addr);
            waitCnt = 0;
            ackLat = (ackMode == 1) ? 1 : int'($urandom_range(0, 3));
        end else begin
            sram_ack = spuriousEn && !sram_req && ($urandom_range(0, 5) == 0);
            sram_rdata = $urandom;
            waitCnt = sram_req ? waitCnt + 1 : 0;
        end
    end

    // Downstream ready: random, always, or a forced stall on a chosen pixel.
    always @(posedge clk) begin
        #1;
        if (readyMode == 0) begin
            pix_ready = ($urandom_range(0, 3) != 0);
        end else if (readyMode == 2 && pix_valid && hsCount == stallIdx && stallLeft > 0) begin
            pix_ready = 1'b0;
            stallLeft--;
        end else begin
            pix_ready = 1'b1;
        end
    end

    // Monitor: samples mid-cycle, so inputs and outputs are settled for the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            expAddrQ.delete();
            expPixQ.delete();
            doneArm = 1'b0;
            zeroStart = 1'b0;
            idlePrev = 1'b0;
            stallPrev = 1'b0;
            reqHoldPrev = 1'b0;
            reqRun = 0;
        end else begin
            expDone = doneArm;
            doneArm = 1'b0;
            if (done || expDone) checkOutput("done_pulse", 32'(done), 32'(expDone));
`ifdef IMG_WR_TIMEOUT_EN
            expErr = sram_req && !sram_ack && (reqRun == 255);
`else
            expErr = 1'b0;
`endif
            if (err || expErr) checkOutput("err_pulse", 32'(err), 32'(expErr));
            if (idlePrev) checkOutput("abort_to_idle", {29'd0, busy, sram_req, pix_valid}, 32'd0);
            if (stallPrev) begin
                checkOutput("stall_valid", 32'(pix_valid), 32'd1);
                checkOutput("stall_data", pix_data, prevData);
                checkOutput("stall_flags", {30'd0, pix_eol, pix_eof}, {30'd0, prevEol, prevEof});
            end
            if (reqHoldPrev) begin
                checkOutput("req_hold", 32'(sram_req), 32'd1);
                checkOutput("req_addr_stable", 32'(sram_addr), 32'(prevAddr));
            end
            if (pix_valid) checkOutput("req_during_out", 32'(sram_req), 32'd0);
            if (sram_req && reqRun == 0) checkOutput("req_expected", 32'(expAddrQ.size() != 0), 32'd1);
            if (zeroStart) begin
                doneArm = 1'b1;
                zeroStart = 1'b0;
            end
            if (abort || expErr) begin
                expAddrQ.delete();
                expPixQ.delete();
            end else begin
                if (sram_req && sram_ack) begin
                    if (expAddrQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL sram_read actual=0x%0h expected=none", sram_addr);
                    end else begin
                        popAddr = expAddrQ.pop_front();
                        checkOutput("sram_addr", 32'(sram_addr), 32'(popAddr));
                    end
                end
                if (pix_valid && pix_ready) begin
                    if (expPixQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL pixel actual=0x%0h expected=none", pix_data);
                    end else begin
                        popPix = expPixQ.pop_front();
                        checkOutput("pix_data", pix_data, popPix.data);
                        checkOutput("pix_eol", 32'(pix_eol), 32'(popPix.eol));
                        checkOutput("pix_eof", 32'(pix_eof), 32'(popPix.eof));
                        doneArm = popPix.eof;
                    end
                    hsCount++;
                end
            end
            idlePrev = abort || expErr;
            stallPrev = pix_valid && !pix_ready && !abort;
            prevData = pix_data;
            prevEol = pix_eol;
            prevEof = pix_eof;
            reqHoldPrev = sram_req && !sram_ack && !abort && !expErr;
            prevAddr = sram_addr;
            reqRun = (sram_req && !sram_ack && !abort) ? reqRun + 1 : 0;
        end
    end

    initial begin
        bit found;
        bit didAbort;
        int k;

        #12;
        checkOutput("reset_ctrl", {25'd0, sram_req, pix_valid, pix_eol, pix_eof, busy, done, err}, 32'd0);
        checkOutput("reset_data", pix_data, 32'd0);
        checkOutput("reset_addr", 32'(sram_addr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] 3x2 frame at 0x100, ack latency 1, ready high");
        applyStimulus(3, 2, 18'h00100);
        waitFrameEnd(100);
        checkOutput("pixels_left_3x2", 32'(expPixQ.size()), 32'd0);

        $display("[TB] 4x1 frame with pixel 2 stalled for 5 cycles");
        readyMode = 2;
        stallIdx = 1;
        stallLeft = 5;
        applyStimulus(4, 1, 18'h00800);
        waitFrameEnd(100);
        checkOutput("stall_consumed", 32'(stallLeft), 32'd0);
        checkOutput("pixels_left_stall", 32'(expPixQ.size()), 32'd0);
        readyMode = 1;

        $display("[TB] zero-size frames");
        applyStimulus(0, 5, 18'h00055);
        repeat (3) begin
            @(negedge clk);
            checkOutput("zero_busy_req", {30'd0, busy, sram_req}, 32'd0);
        end
        waitFrameEnd(10);
        applyStimulus(4, 0, 18'h00066);
        waitFrameEnd(10);

        $display("[TB] abort on same cycle as ack of pixel 2, then wrapping frame");
        applyStimulus(3, 3, 18'h00200);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(posedge clk);
            #2;
            if (sram_req && sram_ack && hsCount == 1) begin
                abort = 1'b1;
                found = 1'b1;
            end
        end
        checkOutput("abort_on_ack_found", 32'(found), 32'd1);
        @(posedge clk);
        #2;
        abort = 1'b0;
        waitFrameEnd(20);
        applyStimulus(3, 3, 18'h3FFFE);
        waitFrameEnd(100);
        checkOutput("pixels_left_wrap", 32'(expPixQ.size()), 32'd0);

        $display("[TB] reset mid-frame");
        applyStimulus(4, 3, 18'h01234);
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midreset_ctrl", {25'd0, sram_req, pix_valid, pix_eol, pix_eof, busy, done, err}, 32'd0);
        checkOutput("midreset_addr", 32'(sram_addr), 32'd0);
        expAddrQ.delete();
        expPixQ.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("post_reset_idle", {29'd0, busy, sram_req, pix_valid}, 32'd0);
        end

        $display("[TB] start while busy is ignored");
        applyStimulus(3, 2, 18'h02000);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("busy_during_frame", 32'(busy), 32'd1);
        img_width = 13'd7;
        img_height = 13'd7;
        base_addr = 18'h0ABCD;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitFrameEnd(100);
        checkOutput("pixels_left_busy_start", 32'(expPixQ.size()), 32'd0);

        $display("[TB] SRAM acknowledge withheld");
        ackMode = 2;
        applyStimulus(2, 1, 18'h00040);
`ifdef IMG_WR_TIMEOUT_EN
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            if (err) found = 1'b1;
        end
        checkOutput("timeout_err_seen", 32'(found), 32'd1);
        ackMode = 1;
        waitFrameEnd(20);
`else
        repeat (300) @(negedge clk);
        checkOutput("no_timeout_req_held", 32'(sram_req), 32'd1);
        checkOutput("no_timeout_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #2;
        abort = 1'b1;
        @(posedge clk);
        #2;
        abort = 1'b0;
        ackMode = 1;
        waitFrameEnd(20);
`endif
        expAddrQ.delete();
        expPixQ.delete();

        $display("[TB] randomized frames");
        ackMode = 0;
        readyMode = 0;
        spuriousEn = 1'b1;
        for (int f = 0; f < 20; f++) begin
            didAbort = 1'b0;
            applyStimulus(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)), 18'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                k = int'($urandom_range(1, 10));
                repeat (k) @(posedge clk);
                #2;
                if (busy) begin
                    abort = 1'b1;
                    @(posedge clk);
                    #2;
                    abort = 1'b0;
                    didAbort = 1'b1;
                end
            end
            waitFrameEnd(1000);
            if (!didAbort) checkOutput("pixels_left_random", 32'(expPixQ.size()), 32'd0);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
